// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master engine among NUM_REQ requesters.
// Latches the winner's command, issues it, waits for completion or timeout, returns status.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_rnw_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic                           timeout_o,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic                           m_start_o,
  output logic [ADDR_W-1:0]              m_addr_o,
  output logic [DATA_W-1:0]              m_data_o,
  output logic                           m_rnw_o,
  input  logic                           m_busy_i,
  input  logic                           m_done_i,
  input  logic                           m_ack_err_i,
  input  logic [DATA_W-1:0]              m_rd_data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  int                sel;

  // Scan downward so the last hit, the nearest index after ptr, takes priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = '0;
    sel     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sel  = (int'(ptr) + k) % NUM_REQ;
      cand = IDX_W'(sel);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_vld) state_n = ISSUE;
      ISSUE:   if (m_start_o && !m_busy_i) state_n = WAIT;
      WAIT:    if (m_done_i || (cnt == CNT_LIMIT)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      idx       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      rd_data_o <= '0;
      m_start_o <= 1'b0;
      m_addr_o  <= '0;
      m_data_o  <= '0;
      m_rnw_o   <= 1'b0;
    end else begin
      state     <= state_n;
      done_o    <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      rd_data_o <= '0;
      m_start_o <= 1'b0;
      cnt       <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx       <= win_idx;
            gnt_o     <= NUM_REQ'(1) << win_idx;
            m_addr_o  <= req_addr_i[win_idx];
            m_data_o  <= req_data_i[win_idx];
            m_rnw_o   <= req_rnw_i[win_idx];
            m_start_o <= !m_busy_i;
          end
        end
        // The strobe is registered, so it reflects the busy flag of the previous cycle.
        ISSUE: begin
          if (state_n != WAIT) m_start_o <= !m_busy_i;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (m_done_i) begin
            done_o    <= gnt_o;
            err_o     <= m_ack_err_i;
            rd_data_o <= m_rnw_o ? m_rd_data_i : '0;
          end else if (cnt == CNT_LIMIT) begin
            done_o    <= gnt_o;
            err_o     <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        DONE: begin
          ptr   <= idx;
          gnt_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: table of transactions plus hand-written
// timeout, busy-master and reset-mid-WAIT sequences.
module tb_i2c_req_arbiter;
  localparam int N  = 5;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 16;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  req_addr_i;
  logic [N-1:0][DW-1:0]  req_data_i;
  logic [N-1:0]          req_rnw_i;
  logic [N-1:0]          gnt_o;
  logic [N-1:0]          done_o;
  logic                  err_o;
  logic                  timeout_o;
  logic [DW-1:0]         rd_data_o;
  logic                  m_start_o;
  logic [AW-1:0]         m_addr_o;
  logic [DW-1:0]         m_data_o;
  logic                  m_rnw_o;
  logic                  m_busy_i;
  logic                  m_done_i;
  logic                  m_ack_err_i;
  logic [DW-1:0]         m_rd_data_i;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_rnw_i(req_rnw_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .timeout_o(timeout_o), .rd_data_o(rd_data_o), .m_start_o(m_start_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_rnw_o(m_rnw_o), .m_busy_i(m_busy_i),
    .m_done_i(m_done_i), .m_ack_err_i(m_ack_err_i), .m_rd_data_i(m_rd_data_i)
  );

  typedef struct {
    logic         rst_b;
    logic [N-1:0] req;
    logic [N-1:0] rnw;
    int           lat;
    logic         ack;
    logic [DW-1:0] rdb;
    logic [N-1:0] gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic         mrnw;
    logic         err;
    logic [DW-1:0] rd;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts and ends in IDLE.
  task automatic run_txn(input vec_t v);
    if (v.rst_b) begin
      rst_i = 1'b1;
      tick;
      rst_i = 1'b0;
    end
    req_i = v.req; req_rnw_i = v.rnw; m_busy_i = 1'b0;
    tick;
    chk("handoff_gnt", 32'(gnt_o), 32'(v.gnt));
    chk("handoff_start", 32'(m_start_o), 32'd1);
    chk("m_addr", 32'(m_addr_o), 32'(v.addr));
    chk("m_data", 32'(m_data_o), 32'(v.data));
    chk("m_rnw", 32'(m_rnw_o), 32'(v.mrnw));
    for (int k = 0; k < v.lat; k++) begin
      tick;
      chk("wait_no_done", 32'(done_o), 32'd0);
      chk("wait_no_start", 32'(m_start_o), 32'd0);
    end
    m_done_i = 1'b1; m_ack_err_i = v.ack; m_rd_data_i = v.rdb;
    tick;
    m_done_i = 1'b0; m_ack_err_i = 1'b0; m_rd_data_i = 8'hEE; req_i = '0;
    chk("done", 32'(done_o), 32'(v.gnt));
    chk("done_gnt_held", 32'(gnt_o), 32'(v.gnt));
    chk("err", 32'(err_o), 32'(v.err));
    chk("timeout", 32'(timeout_o), 32'd0);
    chk("rd_data", 32'(rd_data_o), 32'(v.rd));
    tick;
    chk("idle_gnt", 32'(gnt_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
  endtask

  // Timeout, optionally preceded by a busy master during ISSUE; a late m_done_i in IDLE follows.
  task automatic run_to(input int busy, input logic [N-1:0] req, input logic [N-1:0] g);
    m_busy_i = (busy > 0); req_i = req; req_rnw_i = req;
    tick;
    for (int i = 1; i <= busy; i++) begin
      chk("busy_start", 32'(m_start_o), 32'd0);
      chk("busy_gnt", 32'(gnt_o), 32'(g));
      if (i == busy) m_busy_i = 1'b0;
      tick;
    end
    chk("to_handoff_start", 32'(m_start_o), 32'd1);
    chk("to_handoff_gnt", 32'(gnt_o), 32'(g));
    req_i = '0;
    for (int k = 1; k <= TO; k++) begin
      tick;
      chk("to_wait_no_done", 32'(done_o), 32'd0);
    end
    tick;
    chk("to_done", 32'(done_o), 32'(g));
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_timeout", 32'(timeout_o), 32'd1);
    chk("to_rd_data", 32'(rd_data_o), 32'd0);
    tick;
    m_done_i = 1'b1; m_ack_err_i = 1'b1;
    tick;
    m_done_i = 1'b0; m_ack_err_i = 1'b0;
    chk("late_done", 32'(done_o), 32'd0);
    chk("late_gnt", 32'(gnt_o), 32'd0);
    chk("late_err", 32'(err_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst_i = 1'b1; req_i = '0; req_rnw_i = '0; m_busy_i = 1'b0;
    m_done_i = 1'b0; m_ack_err_i = 1'b0; m_rd_data_i = 8'hEE;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i] = 7'(32'h4E + i);
      req_data_i[i] = 8'(32'hA3 + i);
    end

    //          rst   req       rnw       lat ack rdb    gnt       addr   data   mrnw err rd
    tbl[0]  = '{1'b0, 5'b00100, 5'b00000, 10, 1'b0, 8'h77, 5'b00100, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 5'b11111, 5'b00000,  3, 1'b0, 8'h11, 5'b00001, 7'h4E, 8'hA3, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 5'b11110, 5'b00010,  4, 1'b0, 8'h5A, 5'b00010, 7'h4F, 8'hA4, 1'b1, 1'b0, 8'h5A};
    tbl[3]  = '{1'b0, 5'b11100, 5'b00000,  2, 1'b0, 8'h22, 5'b00100, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 5'b11000, 5'b00000,  5, 1'b0, 8'h33, 5'b01000, 7'h51, 8'hA6, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 5'b10000, 5'b00000,  1, 1'b0, 8'h44, 5'b10000, 7'h52, 8'hA7, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 5'b01001, 5'b00000,  2, 1'b0, 8'h55, 5'b00001, 7'h4E, 8'hA3, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 5'b01000, 5'b00000,  2, 1'b0, 8'h66, 5'b01000, 7'h51, 8'hA6, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 5'b00010, 5'b00010,  6, 1'b1, 8'h3C, 5'b00010, 7'h4F, 8'hA4, 1'b1, 1'b1, 8'h3C};
    tbl[9]  = '{1'b0, 5'b00101, 5'b00000,  1, 1'b0, 8'h88, 5'b00100, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 5'b10001, 5'b00000,  7, 1'b1, 8'hFF, 5'b10000, 7'h52, 8'hA7, 1'b0, 1'b1, 8'h00};

    tick; tick;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_start", 32'(m_start_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    rst_i = 1'b0;
    tick;

    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    run_to(0, 5'b00010, 5'b00010);
    run_to(20, 5'b01000, 5'b01000);

    req_i = 5'b00100; req_rnw_i = '0;
    tick;
    chk("rstw_gnt", 32'(gnt_o), 32'b00100);
    req_i = '0;
    tick; tick; tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("rstw_gnt0", 32'(gnt_o), 32'd0);
    chk("rstw_done0", 32'(done_o), 32'd0);
    chk("rstw_err0", 32'(err_o), 32'd0);
    chk("rstw_timeout0", 32'(timeout_o), 32'd0);
    chk("rstw_rd0", 32'(rd_data_o), 32'd0);
    chk("rstw_start0", 32'(m_start_o), 32'd0);
    chk("rstw_addr0", 32'(m_addr_o), 32'd0);
    chk("rstw_data0", 32'(m_data_o), 32'd0);
    chk("rstw_rnw0", 32'(m_rnw_o), 32'd0);
    m_done_i = 1'b1;
    tick;
    m_done_i = 1'b0;
    chk("rstw_no_done1", 32'(done_o), 32'd0);
    tick;
    chk("rstw_no_done2", 32'(done_o), 32'd0);
    v = '{1'b0, 5'b10001, 5'b00000, 2, 1'b0, 8'h99, 5'b00001, 7'h4E, 8'hA3, 1'b0, 1'b0, 8'h00};
    run_txn(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
